fifo_test_traffic_element: RTL

Self-checking traffic element for FIFO verification: the responder side of the `en`/`fail`/`done` sequencing protocol used by the FIFO test harness. When its `en` rises it pushes a known word sequence into a FIFO under test, pops and checks every word in order, and watches for stalls and surplus data. It then reports a sticky `fail` and drives the shared, pulled-down `done` line until the harness drops `en`. Many elements share one `done` net, so only the enabled element may drive it.

---
 rtl/fifo_test_traffic_element.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_test_traffic_element.sv
// rtl/fifo_test_traffic_element.sv - FIFO test traffic element: push known sequence, pop and check, report fail/done.
// Optional pop stall LFSR enabled by defining FIFO_TEST_STALL_EN.
module fifo_test_traffic_element #(
  parameter int               WIDTH   = 8,
  parameter int               COUNT   = 16,
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(8'h5A),
  parameter int               TIMEOUT = 64,
  parameter int               SETTLE  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic             fail,
  output wire              done,
  output logic             fifo_push,
  output logic [WIDTH-1:0] fifo_wdata,
  input  logic             fifo_full,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_empty
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, FINISH} state_t;

  localparam logic [7:0] COUNT8   = 8'(COUNT);
  localparam logic [7:0] TIMEOUT8 = 8'(TIMEOUT);
  localparam logic [7:0] SETTLE8  = 8'(SETTLE);

  state_t           state_q, state_d;
  logic [7:0]       push_cnt_q, push_cnt_d;
  logic [7:0]       pop_cnt_q, pop_cnt_d;
  logic [7:0]       idle_cnt_q, idle_cnt_d;
  logic [7:0]       settle_cnt_q, settle_cnt_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             pop_ok;
  logic             push_w, pop_w;

`ifdef FIFO_TEST_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign pop_ok = (lfsr_q[1:0] != 2'b00);
`else
  assign pop_ok = 1'b1;
`endif

  assign push_w = (state_q == RUN) && (push_cnt_q < COUNT8) && !fifo_full;
  assign pop_w  = (state_q == RUN) && !fifo_empty && (pop_cnt_q < COUNT8) && pop_ok;

  assign fifo_push  = push_w;
  assign fifo_pop   = pop_w;
  assign fifo_wdata = wdata_q;
  assign fail       = fail_q;
  // Shared pulled-down net: drive only while finished and still enabled.
  assign done       = (done_q && en) ? 1'b1 : 1'bz;

  always_comb begin
    state_d      = state_q;
    push_cnt_d   = push_cnt_q;
    pop_cnt_d    = pop_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    settle_cnt_d = settle_cnt_q;
    fail_d       = fail_q;
    wdata_d      = wdata_q;
    done_d       = (state_q == FINISH) && en;
`ifdef FIFO_TEST_STALL_EN
    lfsr_d       = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d      = RUN;
          fail_d       = 1'b0;
          push_cnt_d   = 8'd0;
          pop_cnt_d    = 8'd0;
          idle_cnt_d   = 8'd0;
          settle_cnt_d = 8'd0;
          wdata_d      = SEED;
`ifdef FIFO_TEST_STALL_EN
          lfsr_d       = 8'h01;
`endif
        end
      end
      RUN: begin
`ifdef FIFO_TEST_STALL_EN
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
        if (push_w) begin
          push_cnt_d = push_cnt_q + 8'd1;
          wdata_d    = wdata_q + WIDTH'(1);
        end
        if (pop_w) begin
          pop_cnt_d = pop_cnt_q + 8'd1;
          if (fifo_rdata != SEED + WIDTH'(pop_cnt_q)) fail_d = 1'b1;
        end
        idle_cnt_d = (push_w || pop_w) ? 8'd0 : idle_cnt_q + 8'd1;
        if (pop_cnt_d == COUNT8) begin
          state_d      = CHECK;
          settle_cnt_d = 8'd0;
        end else if (idle_cnt_d == TIMEOUT8) begin
          fail_d  = 1'b1;
          state_d = FINISH;
        end
      end
      CHECK: begin
        if (!fifo_empty) fail_d = 1'b1;
        settle_cnt_d = settle_cnt_q + 8'd1;
        if (settle_cnt_q + 8'd1 >= SETTLE8) state_d = FINISH;
      end
      FINISH: ;
      default: state_d = IDLE;
    endcase
    // Harness withdrawal aborts any state straight back to IDLE.
    if (!en) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      push_cnt_q   <= 8'd0;
      pop_cnt_q    <= 8'd0;
      idle_cnt_q   <= 8'd0;
      settle_cnt_q <= 8'd0;
      fail_q       <= 1'b0;
      done_q       <= 1'b0;
      wdata_q      <= SEED;
`ifdef FIFO_TEST_STALL_EN
      lfsr_q       <= 8'h01;
`endif
    end else begin
      state_q      <= state_d;
      push_cnt_q   <= push_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      fail_q       <= fail_d;
      done_q       <= done_d;
      wdata_q      <= wdata_d;
`ifdef FIFO_TEST_STALL_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

endmodule
